divu_hilo_unit: RTL

Multi-cycle unsigned divider with architectural HI/LO registers for the pipelined MIPS-Lite CPU. It sits beside the EX stage of `mips_pipeline`. EX pulses `start` when a DIVU (funct 27) leaves ID, and the unit computes quotient and remainder by restoring division, one bit per cycle. It supplies `hi`/`lo` to the MFHI (funct 16) and MFLO (funct 18) datapath, and asks the hazard logic to stall while a result is pending.

---
 rtl/divu_hilo_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit
// Multi-cycle unsigned restoring divider with architectural HI/LO registers.
// One quotient bit per cycle; a result lands in hi/lo WIDTH cycles after start.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle DIVU request, accepted only when idle
//   dividend   in   WIDTH, sampled on an accepted start
//   divisor    in   WIDTH, sampled on an accepted start
//   hilo_rd    in   ID holds an MFHI/MFLO
//   busy       out  division in progress (registered)
//   done       out  one-cycle pulse, hi/lo just updated (registered)
//   hilo_stall out  busy & (hilo_rd | start), combinational
//   hi         out  WIDTH, remainder of last completed DIVU
//   lo         out  WIDTH, quotient of last completed DIVU
module divu_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             hilo_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]  rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]  rem_sh;
    logic [WIDTH:0]  trial;
    logic            trial_ge;

    // Shift {rem, quo} left: quotient MSB enters the remainder LSB.
    assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    // rem_q[WIDTH] is never set after a restoring step; folding it in keeps the
    // compare correct for the full WIDTH+1-bit partial remainder.
    assign trial_ge = rem_q[WIDTH] | (rem_sh >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvs_d   = divisor;
                    quo_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (trial_ge) begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    hi_d    = rem_d[WIDTH-1:0];
                    lo_d    = quo_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign hilo_stall = busy_q & (hilo_rd | start);

endmodule
